// File: rtl/fifo_rd_stream_adapter.sv
// Drains an async FIFO read port into a registered valid/ready stream through a
// 2-entry buffer, and marks every BEAT_COUNT-th accepted beat with m_last.
module fifo_rd_stream_adapter #(
    parameter int WIDTH      = 8,
    parameter int BEAT_COUNT = 4
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_pop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [1:0]       buf_cnt,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(BEAT_COUNT) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEAT_COUNT - 1);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             done_q, done_d;
    logic             pop_s;
    logic             acc_s;
    logic             last_s;

    // Pop depends only on registered occupancy, so m_ready never reaches fifo_pop.
    assign pop_s  = ~rst & ~fifo_empty & (cnt_q != 2'd2);
    assign acc_s  = (cnt_q != 2'd0) & m_ready;
    assign last_s = (beat_q == LAST_BEAT) & (cnt_q != 2'd0);

    assign fifo_pop   = pop_s;
    assign m_valid    = (cnt_q != 2'd0);
    assign m_data     = slot0_q;
    assign m_last     = last_s;
    assign buf_cnt    = cnt_q;
    assign frame_done = done_q;

    // Buffer occupancy, slot steering and frame beat counting.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q + {1'b0, pop_s} - {1'b0, acc_s};

        case (cnt_q)
            2'd0: begin
                if (pop_s) begin
                    slot0_d = fifo_dout;
                end else begin
                    slot0_d = slot0_q;
                end
            end
            2'd1: begin
                // Head leaving while a new word arrives: the new word becomes head.
                if (pop_s && acc_s) begin
                    slot0_d = fifo_dout;
                end else if (pop_s) begin
                    slot1_d = fifo_dout;
                end else begin
                    slot0_d = slot0_q;
                end
            end
            2'd2: begin
                if (acc_s) begin
                    slot0_d = slot1_q;
                end else begin
                    slot0_d = slot0_q;
                end
            end
            default: begin
                slot0_d = slot0_q;
            end
        endcase

        if (acc_s) begin
            if (last_s) begin
                beat_d = '0;
                done_d = 1'b1;
            end else begin
                beat_d = beat_q + CNT_W'(1);
            end
        end else begin
            beat_d = beat_q;
        end
    end

    // State registers; an async reset discards the buffer and any partial frame.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

endmodule
